// File: rtl/hit_input_encoder.sv
// hit_input_encoder
//   Front end of the mole match logic. Each of the five raw mole buttons is
//   brought into the clock domain through a two-flop synchroniser, then
//   debounced independently. The rising edge of a debounced level is a press.
//   A press seen while idle and enabled becomes a 3-bit hit code
//   (001..101 = mole 1..5). The code is held for HOLD_CYCLES cycles. The FSM
//   then waits for every button to be released before it accepts another
//   press, so a single press can never produce more than one code.
//
// Ports
//   clock      in   1  system clock, all logic on posedge
//   reset      in   1  synchronous, active-low
//   enable     in   1  game is in INGAME; presses ignored while low
//   btn_raw    in   5  raw asynchronous buttons, bit i = mole i+1
//   hit        out  3  hit code to the match stage, 000 = no hit
//   hit_valid  out  1  pulse on the first cycle of a new nonzero hit
//   busy       out  1  FSM is in HOLD or RELEASE
//   btn_state  out  5  debounced button levels
//
// FSM states
//   state      | meaning
//   ST_IDLE    | waiting for a press; hit = 0
//   ST_HOLD    | hit code driven, hold_cnt counts down to 0
//   ST_RELEASE | hit = 0, waiting for all debounced buttons to be released

module hit_input_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] btn_raw,
    output logic [2:0] hit,
    output logic       hit_valid,
    output logic       busy,
    output logic [4:0] btn_state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    logic [4:0]      sync_meta;
    logic [4:0]      sync_q;
    logic [DB_W-1:0] db_cnt [5];
    logic [4:0]      btn_state_d;
    logic [4:0]      press;

    state_t          state;
    state_t          state_nxt;
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] hold_cnt_nxt;
    logic [2:0]      hit_nxt;
    logic            hit_valid_nxt;

    // Lowest-numbered mole wins when several presses land on the same cycle.
    function automatic logic [2:0] lowest_code(input logic [4:0] p);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (p[i]) begin
                code = 3'(i + 1);
            end
        end
        return code;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // accepted level, so a change must persist DEBOUNCE_CYCLES consecutive
    // cycles to be accepted; any agreeing cycle restarts it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_state <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync_q[i] == btn_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_state[i] <= sync_q[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_state_d <= '0;
            press       <= '0;
        end else begin
            btn_state_d <= btn_state;
            press       <= btn_state & ~btn_state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            hit       <= 3'd0;
            hit_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            hit       <= hit_nxt;
            hit_valid <= hit_valid_nxt;
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        hit_nxt       = hit;
        hit_valid_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                hit_nxt = 3'd0;
                if (enable && (|press)) begin
                    hit_nxt       = lowest_code(press);
                    hit_valid_nxt = 1'b1;
                    hold_cnt_nxt  = HOLD_LAST;
                    state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    hit_nxt   = 3'd0;
                    state_nxt = ST_RELEASE;
                end else begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end
            end
            ST_RELEASE: begin
                hit_nxt = 3'd0;
                if (btn_state == 5'b0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                hit_nxt      = 3'd0;
                hold_cnt_nxt = '0;
                state_nxt    = ST_IDLE;
            end
        endcase

        // Dropping enable mid-sequence parks the FSM in RELEASE so a button
        // still held when enable returns cannot fire a stale hit.
        if (!enable && (state == ST_HOLD || state == ST_RELEASE)) begin
            hit_nxt       = 3'd0;
            hit_valid_nxt = 1'b0;
            state_nxt     = ST_RELEASE;
        end
    end

endmodule

// File: tb/tb_hit_input_encoder.sv
// tb_hit_input_encoder
//   Directed scenarios plus a randomized phase for hit_input_encoder with
//   DEBOUNCE_CYCLES=4 and HOLD_CYCLES=3. A cycle-level reference model
//   describes the behaviour in terms of consecutive mismatching samples,
//   cycles a code has been shown, and a waiting-for-release flag.

module tb_hit_input_encoder;

    localparam int DB = 4;
    localparam int HC = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [4:0] btn_raw = 5'b0;
    logic [2:0] hit;
    logic       hit_valid;
    logic       busy;
    logic [4:0] btn_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0;
    int last_code = 0;
    bit saw_code5 = 1'b0;

    // reference model
    logic [4:0] m_raw1, m_raw2;
    logic [4:0] m_level, m_level_prev, m_rise;
    int         m_run [5];
    int         m_mode;
    int         m_shown;
    int         m_hit;
    int         m_hv;

    always #5 clock = ~clock;

    hit_input_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .btn_raw  (btn_raw),
        .hit      (hit),
        .hit_valid(hit_valid),
        .busy     (busy),
        .btn_state(btn_state)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [4:0] seen;
        logic [4:0] lvl_old;
        logic [4:0] rise_old;
        int         code;
        if (!reset) begin
            m_raw1 = '0; m_raw2 = '0;
            m_level = '0; m_level_prev = '0; m_rise = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_mode = 0; m_shown = 0; m_hit = 0; m_hv = 0;
        end else begin
            seen     = m_raw2;
            lvl_old  = m_level;
            rise_old = m_rise;
            // a level is accepted on its DB-th consecutive differing sample
            for (int i = 0; i < 5; i++) begin
                if (seen[i] == m_level[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_level[i] = seen[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_rise       = lvl_old & ~m_level_prev;
            m_level_prev = lvl_old;
            m_hv = 0;
            if (!enable) begin
                m_hit = 0;
                if (m_mode != 0) m_mode = 2;
            end else if (m_mode == 0) begin
                m_hit = 0;
                code = 0;
                for (int i = 4; i >= 0; i--) if (rise_old[i]) code = i + 1;
                if (code != 0) begin
                    m_hit = code; m_hv = 1; m_shown = 1; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (m_shown == HC) begin
                    m_hit = 0; m_mode = 2;
                end else begin
                    m_shown++;
                end
            end else begin
                m_hit = 0;
                if (lvl_old == 5'b0) m_mode = 0;
            end
            m_raw2 = m_raw1;
            m_raw1 = btn_raw;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_val("hit", int'(hit), m_hit);
        check_val("hit_valid", int'(hit_valid), m_hv);
        check_val("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        check_val("btn_state", int'(btn_state), int'(m_level));
        if (hit_valid) begin
            n_valid++;
            last_code = int'(hit);
        end
        if (hit == 3'd5) saw_code5 = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int v0;
        bit found;

        // 1: reset with all buttons high
        reset = 1'b0; enable = 1'b0; btn_raw = 5'h1f;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) reset = 1'b1;
            cycle();
            check_val("rst_hit", int'(hit), 0);
            check_val("rst_hv", int'(hit_valid), 0);
            check_val("rst_busy", int'(busy), 0);
            check_val("rst_btn", int'(btn_state), 0);
        end
        btn_raw = 5'b0; enable = 1'b1;
        run(10);

        // 2: mole 3, latency and hold window
        btn_raw = 5'b00100;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check_val("t2_hit", int'(hit), (k >= 8 && k <= 10) ? 3 : 0);
            check_val("t2_hv", int'(hit_valid), (k == 8) ? 1 : 0);
            if (k >= 11) check_val("t2_busy", int'(busy), 1);
        end
        run(5);
        check_val("t2_busy_held", int'(busy), 1);
        btn_raw = 5'b0;
        run(10);
        check_val("t2_idle", int'(busy), 0);

        // 3: short glitch on mole 1
        v0 = n_valid;
        btn_raw = 5'b00001;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) btn_raw = 5'b0;
            cycle();
            check_val("t3_btn0", int'(btn_state[0]), 0);
            check_val("t3_hit", int'(hit), 0);
        end
        check_val("t3_no_valid", n_valid - v0, 0);

        // 4: moles 2 and 5 together
        v0 = n_valid; saw_code5 = 1'b0;
        btn_raw = 5'b10010;
        run(14);
        check_val("t4_one_hit", n_valid - v0, 1);
        check_val("t4_code", last_code, 2);
        btn_raw = 5'b10000;
        run(12);
        check_val("t4_busy_held", int'(busy), 1);
        btn_raw = 5'b0;
        run(12);
        check_val("t4_idle", int'(busy), 0);
        check_val("t4_no_code5", int'(saw_code5), 0);
        check_val("t4_still_one", n_valid - v0, 1);

        // 5: drop enable during hold
        btn_raw = 5'b10000;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (hit_valid) found = 1'b1;
        end
        check_val("t5_wait", int'(found), 1);
        cycle();
        check_val("t5_hold2", int'(hit), 5);
        enable = 1'b0;
        cycle();
        check_val("t5_drop_hit", int'(hit), 0);
        check_val("t5_drop_busy", int'(busy), 1);
        enable = 1'b1;
        v0 = n_valid;
        run(12);
        check_val("t5_no_stale", n_valid - v0, 0);
        check_val("t5_busy", int'(busy), 1);
        btn_raw = 5'b0;
        run(12);
        check_val("t5_idle", int'(busy), 0);
        btn_raw = 5'b10000;
        run(10);
        check_val("t5_repress", n_valid - v0, 1);
        check_val("t5_code", last_code, 5);
        btn_raw = 5'b0;
        run(15);

        // 6: press while disabled, then enable while held
        v0 = n_valid;
        enable = 1'b0;
        btn_raw = 5'b00001;
        run(12);
        enable = 1'b1;
        run(12);
        check_val("t6_no_hit", n_valid - v0, 0);
        btn_raw = 5'b0;
        run(12);
        check_val("t6_idle", int'(busy), 0);

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 99) < 4) btn_raw[b] = ~btn_raw[b];
            end
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 999) == 0) reset = 1'b0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
